qdrc_phy_train_ctrl: RTL

Sequences bring-up of the QDR PHY read path. Waits for the IODELAY controller, writes a fixed training pattern to one QDR address and streams reads of it. It then starts the per-bit training engine and verifies the trained read data, retrying on failure. It sits between the QDR controller's init logic and the PHY bit-training engine and gates `phy_ready` to the user side.

---
 rtl/qdrc_phy_pkg.sv | 22 ++
 rtl/qdrc_phy_pattern_check.sv | 39 +++
 rtl/qdrc_phy_train_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/qdrc_phy_pkg.sv
// Shared definitions for QDR PHY read-path bring-up: controller state encoding and training pattern.
// The pattern constants are kept wide so any DATA_WIDTH up to 64 slices them directly.
package qdrc_phy_pkg;

    localparam int ST_W = 4;

    localparam logic [ST_W-1:0] ST_IDLE     = 4'd0;
    localparam logic [ST_W-1:0] ST_WAIT_RDY = 4'd1;
    localparam logic [ST_W-1:0] ST_WRITE    = 4'd2;
    localparam logic [ST_W-1:0] ST_SETTLE   = 4'd3;
    localparam logic [ST_W-1:0] ST_TRAIN    = 4'd4;
    localparam logic [ST_W-1:0] ST_VERIFY   = 4'd5;
    localparam logic [ST_W-1:0] ST_RETRY    = 4'd6;
    localparam logic [ST_W-1:0] ST_READY    = 4'd7;
    localparam logic [ST_W-1:0] ST_FAIL     = 4'd8;

    localparam int PATTERN_MAX_W = 64;

    localparam logic [PATTERN_MAX_W-1:0] TRAIN_PATTERN_RISE = '1;
    localparam logic [PATTERN_MAX_W-1:0] TRAIN_PATTERN_FALL = '0;

endpackage

// File: rtl/qdrc_phy_pattern_check.sv
// Registered compare of one read beat against the training pattern; match/mismatch strobes
// appear one cycle after a qualified beat. No backpressure: every qualified beat yields one strobe.
module qdrc_phy_pattern_check
    import qdrc_phy_pkg::*;
#(
    parameter int DATA_WIDTH = 18
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  beat_vld_i,
    input  logic [DATA_WIDTH-1:0] rise_i,
    input  logic [DATA_WIDTH-1:0] fall_i,
    output logic                  match_o,
    output logic                  mismatch_o
);

    localparam logic [DATA_WIDTH-1:0] PAT_RISE = TRAIN_PATTERN_RISE[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] PAT_FALL = TRAIN_PATTERN_FALL[DATA_WIDTH-1:0];

    logic hit;
    logic match_q;
    logic mismatch_q;

    assign hit = (rise_i == PAT_RISE) && (fall_i == PAT_FALL);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            match_q    <= 1'b0;
            mismatch_q <= 1'b0;
        end else begin
            match_q    <= beat_vld_i && hit;
            mismatch_q <= beat_vld_i && !hit;
        end
    end

    assign match_o    = match_q;
    assign mismatch_o = mismatch_q;

endmodule

// File: rtl/qdrc_phy_train_ctrl.sv
// QDR PHY read-path bring-up sequencer: write pattern, stream reads, run bit training, verify, retry.
// All outputs registered from next-state (1 cycle); no backpressure, read beats are consumed as they arrive.
module qdrc_phy_train_ctrl
    import qdrc_phy_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 18,
    parameter int                    ADDR_WIDTH    = 21,
    parameter logic [ADDR_WIDTH-1:0] TRAIN_ADDR    = '0,
    parameter int                    SETTLE_CYCLES = 64,
    parameter int                    VERIFY_BEATS  = 256,
    parameter int                    MAX_RETRIES   = 3,
    parameter int                    TRAIN_TIMEOUT = 1 << 20
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  phy_init_start,
    input  logic                  dly_rdy,
    output logic                  phy_ready,
    output logic                  phy_fail,
    output logic [3:0]            retry_count,
    output logic                  train_reset,
    output logic                  train_start,
    input  logic                  train_done,
    input  logic                  train_fail,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data_rise,
    output logic [DATA_WIDTH-1:0] wr_data_fall,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  rd_valid,
    input  logic [DATA_WIDTH-1:0] rd_data_rise,
    input  logic [DATA_WIDTH-1:0] rd_data_fall
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int BW = (VERIFY_BEATS > 0) ? $clog2(VERIFY_BEATS + 1) : 1;
    localparam int TW = (TRAIN_TIMEOUT > 1) ? $clog2(TRAIN_TIMEOUT) : 1;

    localparam logic [SW-1:0] SETTLE_LAST     = SW'(SETTLE_CYCLES - 1);
    localparam logic [SW-1:0] SETTLE_RST_LAST = SW'(1);
    localparam logic [BW-1:0] BEAT_LAST       = BW'(VERIFY_BEATS - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST    = TW'(TRAIN_TIMEOUT - 1);
    localparam logic [3:0]    RETRY_MAX       = 4'(MAX_RETRIES);

    localparam logic [DATA_WIDTH-1:0] PAT_RISE = TRAIN_PATTERN_RISE[DATA_WIDTH-1:0];
    localparam logic [DATA_WIDTH-1:0] PAT_FALL = TRAIN_PATTERN_FALL[DATA_WIDTH-1:0];

    logic [ST_W-1:0] state_q, state_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [3:0]      retry_q, retry_d;

    logic phy_ready_q, phy_fail_q, train_reset_q, train_start_q, wr_en_q, rd_en_q;
    logic phy_ready_d, phy_fail_d, train_reset_d, train_start_d, wr_en_d, rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wr_rise_q, wr_fall_q;

    logic beat_match;
    logic beat_mismatch;

    // Only beats presented while in VERIFY are scored, so the checker's one-cycle
    // latency never lets a stale TRAIN-time beat count toward the pass total.
    qdrc_phy_pattern_check #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_check (
        .clk        (clk),
        .reset_n    (reset_n),
        .beat_vld_i (rd_valid && (state_q == ST_VERIFY)),
        .rise_i     (rd_data_rise),
        .fall_i     (rd_data_fall),
        .match_o    (beat_match),
        .mismatch_o (beat_mismatch)
    );

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        beat_d   = beat_q;
        tmo_d    = tmo_q;
        retry_d  = retry_q;
        case (state_q)
            ST_IDLE:     if (phy_init_start) state_d = ST_WAIT_RDY;
            ST_WAIT_RDY: if (dly_rdy) state_d = ST_WRITE;
            ST_WRITE: begin
                state_d  = ST_SETTLE;
                settle_d = '0;
            end
            ST_SETTLE: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = ST_TRAIN;
                    tmo_d   = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_TRAIN: begin
                if (train_fail) begin
                    state_d = ST_RETRY;
                end else if (train_done) begin
                    state_d = ST_VERIFY;
                    beat_d  = '0;
                end else if (tmo_q == TIMEOUT_LAST) begin
                    state_d = ST_RETRY;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_VERIFY: begin
                if (beat_mismatch) begin
                    state_d = ST_RETRY;
                end else if (beat_match) begin
                    if (beat_q == BEAT_LAST) state_d = ST_READY;
                    else                     beat_d  = beat_q + 1'b1;
                end
            end
            ST_RETRY: begin
                if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + 1'b1;
                    state_d = ST_WAIT_RDY;
                end else begin
                    state_d = ST_FAIL;
                end
            end
            ST_READY, ST_FAIL: state_d = state_q;
            default:           state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_comb begin
        rd_en_d       = (state_d == ST_SETTLE) || (state_d == ST_TRAIN) || (state_d == ST_VERIFY);
        wr_en_d       = (state_d == ST_WRITE);
        phy_ready_d   = (state_d == ST_READY);
        phy_fail_d    = (state_d == ST_FAIL);
        train_start_d = (state_q == ST_SETTLE) && (state_d == ST_TRAIN);
        train_reset_d = (state_d == ST_IDLE) || (state_d == ST_WAIT_RDY) || (state_d == ST_WRITE) ||
                        (state_d == ST_RETRY) || (state_d == ST_FAIL) ||
                        ((state_d == ST_SETTLE) && (settle_d <= SETTLE_RST_LAST));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            settle_q      <= '0;
            beat_q        <= '0;
            tmo_q         <= '0;
            retry_q       <= '0;
            phy_ready_q   <= 1'b0;
            phy_fail_q    <= 1'b0;
            train_reset_q <= 1'b1;
            train_start_q <= 1'b0;
            wr_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            addr_q        <= '0;
            wr_rise_q     <= '0;
            wr_fall_q     <= '0;
        end else begin
            state_q       <= state_d;
            settle_q      <= settle_d;
            beat_q        <= beat_d;
            tmo_q         <= tmo_d;
            retry_q       <= retry_d;
            phy_ready_q   <= phy_ready_d;
            phy_fail_q    <= phy_fail_d;
            train_reset_q <= train_reset_d;
            train_start_q <= train_start_d;
            wr_en_q       <= wr_en_d;
            rd_en_q       <= rd_en_d;
            addr_q        <= TRAIN_ADDR;
            wr_rise_q     <= wr_en_d ? PAT_RISE : '0;
            wr_fall_q     <= wr_en_d ? PAT_FALL : '0;
        end
    end

    assign phy_ready    = phy_ready_q;
    assign phy_fail     = phy_fail_q;
    assign retry_count  = retry_q;
    assign train_reset  = train_reset_q;
    assign train_start  = train_start_q;
    assign wr_en        = wr_en_q;
    assign wr_addr      = addr_q;
    assign wr_data_rise = wr_rise_q;
    assign wr_data_fall = wr_fall_q;
    assign rd_en        = rd_en_q;
    assign rd_addr      = addr_q;

endmodule
